bus_memory: RTL and testbench

Memory-bus responder for the drisc core: the slave end of the core's pad interface (`address_bus`, `write_address`, `read`, `write`, `data_size`, `data_bus_out`, `data_bus_out_enable`, `data_bus_in`). It latches addresses, performs byte/half/word stores with lane steering into an internal word-organised RAM, and returns registered, zero-extended read data to the core. It sits outside the core as the single program/data memory in simulation and FPGA builds.

---
 rtl/bus_memory.sv | 89 ++++++++
 tb/tb_bus_memory.sv | 131 +++++++++++++
 2 files changed

// File: rtl/bus_memory.sv
// bus_memory: word-organised RAM slave for the drisc core pad bus with lane-steered stores and zero-extended loads.
//
// Ports:
//   clock, reset (async active-low)
//   address_bus, write_address       : byte address and its latch strobe (bypassed the same cycle)
//   read, write, data_size           : access strobes and size (0 byte, 1 half, 2/3 word)
//   data_bus_out, data_bus_out_enable: right-aligned store data and its valid
//   data_bus_in                      : registered, right-aligned, zero-extended load data
//   fault, fault_sticky              : access-fault pulse and sticky flag
//
// Build option: define BUS_MEMORY_FAULT_EN to check alignment, size and range;
// otherwise misaligned accesses truncate, addresses wrap and both fault outputs stay 0.
module bus_memory #(
  parameter int          DEPTH_WORDS  = 1024,
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_bus,
  input  logic        write_address,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_bus_out,
  input  logic        data_bus_out_enable,
  output logic [31:0] data_bus_in,
  output logic        fault,
  output logic        fault_sticky
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'd4;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] addr_q, addr_d, data_q, data_d;
  logic [31:0] ea, off, word, rdata, wdata;
  logic [AW-1:0] idx;
  logic [1:0] lane;
  logic [3:0] be;
  logic fault_q, sticky_q, fault_d, fault_en, bad, acc_w, acc_r, we;
`ifdef BUS_MEMORY_FAULT_EN
  assign fault_en = 1'b1;
`else
  assign fault_en = 1'b0;
`endif
  assign ea   = write_address ? address_bus : addr_q;
  assign off  = ea - BASE_ADDRESS;
  assign idx  = off[AW+1:2];
  assign lane = ea[1:0];
  assign word = mem[idx];
  // A simultaneous read is dropped whenever write is high, even if no store happens.
  assign acc_w = write & data_bus_out_enable;
  assign acc_r = read & ~write;
  // Below-base addresses wrap to huge offsets, so one unsigned compare covers both range ends.
  assign bad = (data_size == 2'd3) || (data_size == 2'd1 && ea[0]) ||
               (data_size == 2'd2 && |ea[1:0]) || ({1'b0, off} >= SPAN);
  assign fault_d = fault_en & (acc_w | acc_r) & bad;
  assign we = acc_w & ~fault_d;
  always_comb begin
    be    = data_size == 2'd0 ? 4'b0001 << lane :
            data_size == 2'd1 ? (lane[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata = data_size == 2'd0 ? {4{data_bus_out[7:0]}} :
            data_size == 2'd1 ? {2{data_bus_out[15:0]}} : data_bus_out;
    rdata = data_size == 2'd0 ? {24'b0, word[{lane, 3'b000} +: 8]} :
            data_size == 2'd1 ? {16'b0, word[{lane[1], 4'b0000} +: 16]} : word;
    addr_d = write_address ? address_bus : addr_q;
    data_d = acc_r ? (fault_d ? 32'b0 : rdata) : data_q;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      addr_q   <= '0;
      data_q   <= '0;
      fault_q  <= 1'b0;
      sticky_q <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      fault_q  <= fault_d;
      sticky_q <= sticky_q | fault_d;
    end
  end
  // RAM is not reset; a store coinciding with reset is discarded.
  always_ff @(posedge clock) begin
    if (reset && we)
      for (int i = 0; i < 4; i++)
        if (be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
  end
  assign data_bus_in  = data_q;
  assign fault        = fault_q;
  assign fault_sticky = sticky_q;
endmodule

// File: tb/tb_bus_memory.sv
// tb_bus_memory: directed plus random checks of bus_memory against a byte-addressed reference model.
module tb_bus_memory;
  localparam int DEPTH = 64;
  localparam int NB = DEPTH * 4;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef BUS_MEMORY_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b0;
  logic [31:0] address_bus = '0, data_bus_out = '0;
  logic write_address = 1'b0, read = 1'b0, write = 1'b0, data_bus_out_enable = 1'b0;
  logic [1:0] data_size = 2'd2;
  logic [31:0] data_bus_in;
  logic fault, fault_sticky;
  int checks = 0, passed = 0;
  logic [7:0] m [NB];
  logic [31:0] addr_m = '0, din_m = '0;
  logic fault_m = 1'b0, sticky_m = 1'b0;

  bus_memory #(.DEPTH_WORDS(DEPTH), .BASE_ADDRESS(BASE)) dut (
    .clock(clock), .reset(reset), .address_bus(address_bus), .write_address(write_address),
    .read(read), .write(write), .data_size(data_size), .data_bus_out(data_bus_out),
    .data_bus_out_enable(data_bus_out_enable), .data_bus_in(data_bus_in),
    .fault(fault), .fault_sticky(fault_sticky));

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    check({tag, ".data"}, data_bus_in, din_m);
    check({tag, ".fault"}, {31'b0, fault}, {31'b0, fault_m});
    check({tag, ".sticky"}, {31'b0, fault_sticky}, {31'b0, sticky_m});
  endtask

  // One bus cycle: drive, clock, update the model from the access rules, then compare.
  task automatic cyc(input string tag, input logic wa, input logic [31:0] a, input logic rd,
                     input logic wr, input logic en, input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] ea, off, b, v;
    int n;
    logic f, bad;
    write_address = wa; address_bus = a; read = rd; write = wr;
    data_bus_out_enable = en; data_size = sz; data_bus_out = d;
    @(posedge clock);
    if (reset) begin
      ea = wa ? a : addr_m;
      if (wa) addr_m = a;
      off = ea - BASE;
      n = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
      bad = sz == 2'd3 || (ea % n) != 0 || off >= NB;
      f = FEN && ((wr && en) || (rd && !wr)) && bad;
      b = (off - (off % n)) % NB;
      if (wr && en && !f)
        for (int k = 0; k < n; k++) m[(b + k) % NB] = d[8*k +: 8];
      if (rd && !wr) begin
        v = '0;
        for (int k = 0; k < n; k++) v = v + ({24'b0, m[(b + k) % NB]} << (8 * k));
        din_m = f ? 32'b0 : v;
      end
      fault_m = f;
      sticky_m = sticky_m | f;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [31:0] a, d;
    logic [1:0] sz;
    #2;
    check_all("reset");
    reset = 1'b1;
    @(posedge clock); #1;
    for (int i = 0; i < DEPTH; i++) cyc("fill", 1'b1, BASE + 32'(4 * i), 1'b0, 1'b1, 1'b1, 2'd2, $urandom);
    cyc("wa10", 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 2'd2, 0);
    cyc("wr_beef", 1'b0, 0, 1'b0, 1'b1, 1'b1, 2'd2, 32'hDEADBEEF);
    cyc("rd_beef", 1'b0, 0, 1'b1, 1'b0, 1'b0, 2'd2, 0);
    check("deadbeef", data_bus_in, 32'hDEADBEEF);
    cyc("wr_11223344", 1'b1, 32'h10, 1'b0, 1'b1, 1'b1, 2'd2, 32'h11223344);
    cyc("wr_byte", 1'b1, 32'h13, 1'b0, 1'b1, 1'b1, 2'd0, 32'h000000AA);
    cyc("rd_word10", 1'b1, 32'h10, 1'b1, 1'b0, 1'b0, 2'd2, 0);
    check("aa223344", data_bus_in, 32'hAA223344);
    cyc("rd_byte13", 1'b1, 32'h13, 1'b1, 1'b0, 1'b0, 2'd0, 0);
    check("byte_aa", data_bus_in, 32'h000000AA);
    cyc("clr20", 1'b1, 32'h20, 1'b0, 1'b1, 1'b1, 2'd2, 0);
    cyc("wr_half", 1'b1, 32'h22, 1'b0, 1'b1, 1'b1, 2'd1, 32'h1234BEEF);
    cyc("rd_word20", 1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 2'd2, 0);
    check("beef0000", data_bus_in, 32'hBEEF0000);
    cyc("rd_half22", 1'b1, 32'h22, 1'b1, 1'b0, 1'b0, 2'd1, 0);
    check("half_beef", data_bus_in, 32'h0000BEEF);
    cyc("wr30", 1'b1, 32'h30, 1'b0, 1'b1, 1'b1, 2'd2, 32'h30303030);
    cyc("wa10b", 1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 2'd2, 0);
    cyc("bypass30", 1'b1, 32'h30, 1'b1, 1'b0, 1'b0, 2'd2, 0);
    check("bypass_val", data_bus_in, 32'h30303030);
    cyc("wr_rd", 1'b1, 32'h34, 1'b1, 1'b1, 1'b1, 2'd2, 32'h5A5A5A5A);
    check("wr_rd_hold", data_bus_in, 32'h30303030);
    cyc("rd34", 1'b1, 32'h34, 1'b1, 1'b0, 1'b0, 2'd2, 0);
    cyc("wr_noen", 1'b1, 32'h34, 1'b0, 1'b1, 1'b0, 2'd2, 32'hFFFFFFFF);
    cyc("rd34b", 1'b1, 32'h34, 1'b1, 1'b0, 1'b0, 2'd2, 0);
    cyc("mis_word", 1'b1, 32'h41, 1'b0, 1'b1, 1'b1, 2'd2, 32'h41414141);
    cyc("rd40", 1'b1, 32'h40, 1'b1, 1'b0, 1'b0, 2'd2, 0);
    cyc("rd_oor", 1'b1, BASE + 32'(NB), 1'b1, 1'b0, 1'b0, 2'd2, 0);
    cyc("sz3", 1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 2'd3, 0);
    cyc("wr50", 1'b1, 32'h50, 1'b0, 1'b1, 1'b1, 2'd2, 32'hCAFEF00D);
    cyc("rd50", 1'b1, 32'h50, 1'b1, 1'b0, 1'b0, 2'd2, 0);
    reset = 1'b0;
    #1;
    addr_m = '0; din_m = '0; fault_m = 1'b0; sticky_m = 1'b0;
    check_all("async_rst");
    cyc("wr_in_rst", 1'b1, 32'h50, 1'b0, 1'b1, 1'b1, 2'd2, 32'h0BADBAD0);
    reset = 1'b1;
    cyc("rd_addr0", 1'b0, 0, 1'b1, 1'b0, 1'b0, 2'd2, 0);
    cyc("rd50_kept", 1'b1, 32'h50, 1'b1, 1'b0, 1'b0, 2'd2, 0);
    check("cafef00d", data_bus_in, 32'hCAFEF00D);
    for (int i = 0; i < 1500; i++) begin
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 2 * NB - 1));
      sz = 2'($urandom_range(0, 3));
      d = $urandom;
      cyc("rand", 1'($urandom_range(0, 3) != 0), a, 1'($urandom), 1'($urandom),
          1'($urandom_range(0, 3) != 0), sz, d);
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
